grf_wb_queue: RTL
=================

Name: grf_wb_queue

Overview:
- Write-back side of the general register file: the block that produces the register-file write port (we/a3/wd/pc) instead of consuming it.
- Accepts register write requests from execute/memory producers through a valid/ready handshake.
- Buffers them in an in-order FIFO and retires one write per cycle to the register file.
- Provides read-after-write lookups so that read stages see data still waiting in the queue.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), width of the read/write pointers; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears the queue.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept a request.
- in_addr  in  5  destination register number.
- in_data  in  32  data to write.
- in_pc  in  32  address of the producing instruction, carried for the write trace.
- stall  in  1  hold retirement this cycle.
- we  out  1  register-file write enable.
- a3  out  5  register-file write address.
- wd  out  32  register-file write data.
- pc  out  32  register-file trace pc.
- q_a1  in  5  lookup address 1.
- q_a2  in  5  lookup address 2.
- hit1  out  1  q_a1 matches a queued entry.
- hit2  out  1  q_a2 matches a queued entry.
- fwd1  out  32  data for q_a1.
- fwd2  out  32  data for q_a2.
- empty  out  1  no entries queued.
- full  out  1  DEPTH entries queued.

Behaviour:
- Reset (asynchronous, immediate):
  - wr_ptr, rd_ptr and count clear to 0.
  - All entry valid bits clear; entry contents are don't-care.
  - Resulting outputs: we=0, a3=0, wd=0, pc=0, in_ready=1, empty=1, full=0, hit1=hit2=0, fwd1=fwd2=0.
- Reset mid-operation discards all queued writes; none reach the register file.
- Handshake:
  - in_ready = !full, combinational.
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - in_addr, in_data and in_pc are sampled only at that edge.
- Register-zero filter: a transfer with in_addr==0 completes the handshake but is dropped. No entry is allocated, and count and wr_ptr are unchanged.
- Retirement:
  - we = !empty && !stall, combinational.
  - a3, wd and pc come combinationally from the head entry when we=1; all three are 0 otherwise.
  - At the rising edge with we=1 the head pops (rd_ptr+1, count-1). The register file captures the write at the same edge.
  - Latency from enqueue edge to the earliest write edge: 1 cycle (the entry becomes head the following cycle).
- Simultaneous push and pop:
  - When not full, both happen and count is unchanged.
  - When full, in_ready=0, so there is no same-cycle pass-through even if the head pops.
  - in_ready rises the cycle after the pop.
- Pointer wrap: pointers are PTR_W bits and wrap modulo DEPTH. full and empty are derived from count, which is PTR_W+1 bits.
- Ordering: strictly FIFO. Duplicate addresses are kept and retired in order, so the last write wins in the register file.
- Lookup (see Optional Feature):
  - hitN=1 when qN!=0 and at least one valid entry, head included, has addr==qN.
  - fwdN is the data of the youngest matching entry; fwdN=0 when there is no hit.
  - The lookup is combinational on current contents; a request being enqueued this cycle is not visible.
- stall only freezes retirement. Enqueue continues until full.

Optional Feature:
- Macro: GRF_WBQ_BYPASS_EN.
- Defined: the lookup logic above is present.
- Undefined: hit1=hit2=0 and fwd1=fwd2=0 constantly. q_a1/q_a2 are ignored and no comparators are synthesised. Producers must stall on a non-empty queue instead.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_ADDR_W=5, WORD_W=32.
  - REG_ZERO=5'd0.
  - typedef wb_entry_t {addr, data, pc}.
- One natural sub-module, grf_wbq_match: a priority search returning hit and data of the youngest match given entries, valid bits, rd_ptr and a query address.
  - Instantiated twice, only under GRF_WBQ_BYPASS_EN.

Test Plan:
- Reset with 3 entries queued: assert reset between edges -> we=0, empty=1, in_ready=1 immediately; no further writes appear on we.
- Enqueue (5,0x11111111,pc 0x3000) -> next cycle we=1, a3=5, wd=0x11111111, pc=0x3000; the cycle after, empty=1.
- Fill under stall=1 with addrs 1..4 -> full=1, in_ready=0 and a 5th request is held. Release stall -> writes 1,2,3,4 on consecutive cycles, and in_ready=1 the cycle after the first pop.
- Enqueue addr 0 with data 0xDEADBEEF -> handshake completes, count stays 0, we never asserts.
- Bypass (macro defined): queue (7,0xA), (7,0xB) under stall with q_a1=7, q_a2=0 -> hit1=1, fwd1=0xB, hit2=0. Macro undefined -> hit1=0, fwd1=0.
- Wrap: 10 back-to-back enqueues with stall=0 and DEPTH=4 -> 10 writes in order, with no loss or duplication across pointer wrap.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register/word widths, the hard-wired zero register
// and the write-back entry record carried through the write-back queue.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     data;
    logic [WORD_W-1:0]     pc;
  } wb_entry_t;
endpackage

// File: rtl/grf_wb_queue_if.sv
// Bus bundle of the register-file write-back queue: producer enqueue channel,
// register-file write port, read-after-write lookup and occupancy flags.
interface grf_wb_queue_if;
  import cpu_pkg::*;

  // Enqueue handshake: a request transfers on a rising edge where in_valid and
  // in_ready are both high; in_addr/in_data/in_pc are sampled only at that edge
  // and the producer holds them stable while in_valid is high and in_ready low.
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_addr;
  logic [WORD_W-1:0]     in_data;
  logic [WORD_W-1:0]     in_pc;

  logic                  stall;
  logic                  we;
  logic [REG_ADDR_W-1:0] a3;
  logic [WORD_W-1:0]     wd;
  logic [WORD_W-1:0]     pc;

  logic [REG_ADDR_W-1:0] q_a1;
  logic [REG_ADDR_W-1:0] q_a2;
  logic                  hit1;
  logic                  hit2;
  logic [WORD_W-1:0]     fwd1;
  logic [WORD_W-1:0]     fwd2;

  logic                  empty;
  logic                  full;

  modport master (
    output in_valid, in_addr, in_data, in_pc, stall, q_a1, q_a2,
    input  in_ready, we, a3, wd, pc, hit1, hit2, fwd1, fwd2, empty, full
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_pc, stall, q_a1, q_a2,
    output in_ready, we, a3, wd, pc, hit1, hit2, fwd1, fwd2, empty, full
  );
endinterface

// File: rtl/grf_wbq_match.sv
// Youngest-match search over the write-back queue: walks entries from the head
// (oldest) towards the tail so the last hit seen is the youngest one.
module grf_wbq_match
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t             entries [DEPTH],
  input  logic [DEPTH-1:0]      valid,
  input  logic [PTR_W-1:0]      rd_ptr,
  input  logic [REG_ADDR_W-1:0] q,
  output logic                  hit,
  output logic [WORD_W-1:0]     data
);
  logic [PTR_W-1:0] idx;
  logic             unused_pc;

  always_comb begin
    hit       = 1'b0;
    data      = '0;
    idx       = '0;
    unused_pc = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx       = rd_ptr + PTR_W'(k);
      unused_pc = unused_pc ^ (^entries[k].pc);
      if (q != REG_ZERO && valid[idx] && entries[idx].addr == q) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/grf_wb_queue.sv
// In-order register-file write-back queue retiring one write per cycle.
// Build option GRF_WBQ_BYPASS_EN adds read-after-write lookup of queued data.
module grf_wb_queue
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  grf_wb_queue_if.slave  wb
);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  assign wb.full     = (count == DEPTH_C);
  assign wb.empty    = (count == '0);
  assign wb.in_ready = !wb.full;
  // Writes to register zero complete the handshake but never occupy an entry.
  assign push        = wb.in_valid && wb.in_ready && (wb.in_addr != REG_ZERO);
  assign pop         = wb.we;

  assign wb.we = !wb.empty && !wb.stall;
  assign wb.a3 = wb.we ? mem[rd_ptr].addr : '0;
  assign wb.wd = wb.we ? mem[rd_ptr].data : '0;
  assign wb.pc = wb.we ? mem[rd_ptr].pc   : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + 1'b1;
        vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry contents need no reset: they are only observed through valid slots.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: wb.in_addr, data: wb.in_data, pc: wb.in_pc};
    end
  end

`ifdef GRF_WBQ_BYPASS_EN
  grf_wbq_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (mem),
    .valid   (vld),
    .rd_ptr  (rd_ptr),
    .q       (wb.q_a1),
    .hit     (wb.hit1),
    .data    (wb.fwd1)
  );

  grf_wbq_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (mem),
    .valid   (vld),
    .rd_ptr  (rd_ptr),
    .q       (wb.q_a2),
    .hit     (wb.hit2),
    .data    (wb.fwd2)
  );
`else
  logic unused_lookup;

  assign unused_lookup = ^{wb.q_a1, wb.q_a2, vld};
  assign wb.hit1 = 1'b0;
  assign wb.hit2 = 1'b0;
  assign wb.fwd1 = '0;
  assign wb.fwd2 = '0;
`endif
endmodule
